state_table_loader: RTL

- Writer-side counterpart of the team's ROM-driven Moore machines: a 2^ADDR_W-entry state table loaded at runtime over a valid/ready write port.
- Once loaded, the block executes the table as a Moore FSM.
- Table address is {A, current state}. Each entry is {next_state, outputs}.
- Sits between a host/test sequencer and the controlled plant. It replaces hardwired tables so one netlist can run any FSM.

---
 rtl/state_table_pkg.sv | 24 ++
 rtl/state_table_ram.sv | 50 +++++
 rtl/state_table_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/state_table_pkg.sv
// rtl/state_table_pkg.sv - mode encoding, default widths and entry field helpers for the state table loader
package state_table_pkg;

  localparam int STATE_W_DFLT = 3;
  localparam int OUT_W_DFLT   = 6;
  localparam int ENTRY_W      = STATE_W_DFLT + OUT_W_DFLT;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_ERR  = 2'b11
  } mode_e;

  // Entry layout: next state occupies the top STATE_W bits, outputs the low OUT_W bits.
  function automatic int entry_width(input int state_w, input int out_w);
    return state_w + out_w;
  endfunction

  function automatic int next_lsb(input int out_w);
    return out_w;
  endfunction

endpackage

// File: rtl/state_table_ram.sv
// rtl/state_table_ram.sv - table storage with written-mask; readback port under STATE_TABLE_READBACK_EN
module state_table_ram
  import state_table_pkg::*;
#(
  parameter int STATE_W = STATE_W_DFLT,
  parameter int OUT_W   = OUT_W_DFLT,
  parameter int ADDR_W  = STATE_W + 1
) (
  input  logic                              clk,
  input  logic                              res,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [entry_width(STATE_W,OUT_W)-1:0] wr_data,
  input  logic [ADDR_W-1:0]                 run_addr,
  output logic [entry_width(STATE_W,OUT_W)-1:0] run_data,
  output logic                              run_written
`ifdef STATE_TABLE_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [entry_width(STATE_W,OUT_W)-1:0] rd_data,
  output logic                              rd_written
`endif
);

  localparam int EW    = entry_width(STATE_W, OUT_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [EW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] mask;

  // Table contents need no reset: the mask hides anything not written since reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Written-mask: cleared by reset, one bit set per accepted write.
  always_ff @(posedge clk) begin
    if (!res)       mask <= '0;
    else if (wr_en) mask[wr_addr] <= 1'b1;
  end

  assign run_data    = mem[run_addr];
  assign run_written = mask[run_addr];

`ifdef STATE_TABLE_READBACK_EN
  assign rd_written = mask[rd_addr];
  assign rd_data    = mask[rd_addr] ? mem[rd_addr] : '0;
`endif

endmodule

// File: rtl/state_table_loader.sv
// rtl/state_table_loader.sv - runtime-loaded Moore state table; STATE_TABLE_READBACK_EN adds rd_addr/rd_data/rd_written
module state_table_loader
  import state_table_pkg::*;
#(
  parameter int STATE_W = STATE_W_DFLT,
  parameter int OUT_W   = OUT_W_DFLT,
  parameter int ADDR_W  = STATE_W + 1
) (
  input  logic                                  clk,
  input  logic                                  res,
  input  logic                                  load_en,
  input  logic                                  run,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [entry_width(STATE_W,OUT_W)-1:0] wr_data,
  input  logic                                  A,
  output logic [OUT_W-1:0]                      outs,
  output logic [STATE_W-1:0]                    state,
  output logic [1:0]                            mode,
  output logic                                  err
`ifdef STATE_TABLE_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]                     rd_addr,
  output logic [entry_width(STATE_W,OUT_W)-1:0] rd_data,
  output logic                                  rd_written
`endif
);

  localparam int EW  = entry_width(STATE_W, OUT_W);
  localparam int NSL = next_lsb(OUT_W);

  mode_e              mode_q, mode_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   outs_q, outs_d;
  logic [ADDR_W-1:0]  run_addr;
  logic [EW-1:0]      run_entry;
  logic               run_written;
  logic               wr_en;

  assign wr_ready = (mode_q == MODE_LOAD);
  assign wr_en    = wr_valid & wr_ready;
  assign run_addr = {A, state_q};

  state_table_ram #(
    .STATE_W (STATE_W),
    .OUT_W   (OUT_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk         (clk),
    .res         (res),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .run_addr    (run_addr),
    .run_data    (run_entry),
    .run_written (run_written)
`ifdef STATE_TABLE_READBACK_EN
    ,
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_written  (rd_written)
`endif
  );

  // Mode, state and output registers; reset aborts whatever mode is active.
  always_ff @(posedge clk) begin
    if (!res) begin
      mode_q  <= MODE_IDLE;
      state_q <= '0;
      outs_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

  // Next mode plus one table step per RUN cycle; an unwritten entry traps into ERR.
  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    outs_d  = outs_q;
    case (mode_q)
      MODE_IDLE: begin
        if (load_en) begin
          mode_d = MODE_LOAD;
        end else if (run) begin
          mode_d  = MODE_RUN;
          state_d = '0;
        end
      end
      MODE_LOAD: begin
        if (!load_en) mode_d = MODE_IDLE;
      end
      MODE_RUN: begin
        if (!run) begin
          mode_d = MODE_IDLE;
        end else if (run_written) begin
          state_d = run_entry[EW-1:NSL];
          outs_d  = run_entry[OUT_W-1:0];
        end else begin
          mode_d = MODE_ERR;
          outs_d = '0;
        end
      end
      MODE_ERR: begin
        outs_d = '0;
        if (load_en) mode_d = MODE_LOAD;
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  assign outs  = outs_q;
  assign state = state_q;
  assign mode  = mode_q;
  assign err   = (mode_q == MODE_ERR);

endmodule
